gate_unit_pipe: RTL
===================

// Module: gate_unit_pipe
// PURPOSE
//  - Parametrised, pipelined successor to the single-function dataflow gates.
//  - Applies one of eight bitwise ops to WIDTH-bit operands a/b, selected per transaction.
//  - Two register stages with valid/ready handshakes on input and output; full throughput.
//  - Used wherever gate functions must be time-multiplexed in clocked datapaths.
// PARAMETERS
//  WIDTH  8   operand/result width in bits (>=1)
//  CNT_W  16  width of op_count (only used when GATE_UNIT_STATUS_EN defined)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      a/b/op valid
//  in_ready   out  1      unit accepts input this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  op         in   3      operation select (encoding below)
//  out_valid  out  1      y/flags valid
//  out_ready  in   1      consumer accepts output this cycle
//  y          out  WIDTH  result
//  zero       out  1      y == 0
//  all_ones   out  1      y == all ones
//  op_count   out  CNT_W  accepted-transaction count (GATE_UNIT_STATUS_EN only)
// BEHAVIOUR
//  - Reset (rst_n low, async): s1/s2 valid=0, out_valid=0, y=0, zero=0, all_ones=0, op_count=0.
//  - op: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT a (b ignored), 7 BUF a.
//  - Input transfer: in_valid && in_ready at a rising edge. Output transfer: out_valid && out_ready.
//  - Stage 1 registers a, b, op. Stage 2 registers y = f(op,a,b), zero, and all_ones.
//  - Latency: 2 cycles from input transfer to out_valid, with no stall.
//  - s2_adv = !out_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv.
//  - in_ready may depend combinationally on out_ready. No combinational path from in_valid to out_valid.
//  - Stall: while out_valid && !out_ready, y/zero/all_ones/out_valid hold stable.
//  - Stall: a pending stage-1 item holds. in_ready drops once both stages are full.
//  - Simultaneous transfer: with both stages full and out_ready=1, all stages advance in one cycle.
//  - At 100% throughput there are no bubbles and no loss or duplication.
//  - Inputs: a/b/op are sampled only on transfer and may change freely otherwise.
//  - Inputs: in_valid does not need to be held. Dropping it simply withdraws the offer.
//  - Bubbles: empty stage-1 with s2_adv=1 clears out_valid after the last output transfer.
//  - Reset mid-operation: all in-flight items are discarded immediately.
//  - Reset mid-operation: nothing from before reset is emitted after rst_n rises.
//  - WIDTH=1: zero = ~y and all_ones = y, with the same timing.
// CONFIGURATION
//  - Macro GATE_UNIT_STATUS_EN.
//  - Defined: op_count port exists and increments by 1 on every input transfer.
//  - Defined: op_count wraps from 2^CNT_W-1 to 0 and resets to 0.
//  - Not defined: op_count port and its counter are absent. All other behaviour is identical.
// STRUCTURE
//  - Package gate_unit_pkg: op encoding constants (OP_AND..OP_BUF) and OP_W=3.
//  - Sub-module gate_unit_core: purely combinational f(op,a,b) -> y, WIDTH parametrised.
//  - Top: handshake/pipeline registers, flag generation, optional counter.
// TESTING (WIDTH=8, CNT_W=4 where relevant)
//  1. Basic NAND: a=F0, b=CC, op=2, out_ready=1 -> out_valid 2 cycles later, y=3F, zero=0, all_ones=0.
//  2. Op sweep: a=F0, b=CC, ops 0..7 back-to-back.
//     Required y sequence: C0, FC, 3F, 03, 3C, C3, 0F, F0.
//     One result per cycle, no bubbles.
//  3. Flags: op=0 with a=F0, b=0F -> y=00, zero=1. op=2 with the same operands -> y=FF, all_ones=1.
//  4. Backpressure: stream 5 items, hold out_ready=0 for 4 cycles.
//     Required: y stays stable and in_ready=0 once 2 items are held.
//     After release, all 5 arrive in order, unduplicated.
//  5. Reset mid-stream: assert rst_n=0 with 2 items in flight.
//     Required: out_valid=0 and y=00 immediately. No output after release until new input arrives.
//  6. GATE_UNIT_STATUS_EN: 17 transfers -> op_count=1 (wrap). Without the macro, the build has no op_count port.

Source files
------------

// File: rtl/gate_unit_pkg.sv
// Shared definitions for the gate unit: operation-select width and encodings.
package gate_unit_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W-1:0] OP_NAND = 3'd2;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
  localparam logic [OP_W-1:0] OP_NOT  = 3'd6;
  localparam logic [OP_W-1:0] OP_BUF  = 3'd7;

endpackage

// File: rtl/gate_unit_core.sv
// Purely combinational bitwise function y = f(op, a, b), WIDTH bits wide.
module gate_unit_core
  import gate_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [OP_W-1:0]  i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_y
);

  always_comb begin
    o_y = '0;
    case (i_op)
      OP_AND:  o_y = i_a & i_b;
      OP_OR:   o_y = i_a | i_b;
      OP_NAND: o_y = ~(i_a & i_b);
      OP_NOR:  o_y = ~(i_a | i_b);
      OP_XOR:  o_y = i_a ^ i_b;
      OP_XNOR: o_y = ~(i_a ^ i_b);
      OP_NOT:  o_y = ~i_a;
      OP_BUF:  o_y = i_a;
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/gate_unit_pipe.sv
// Two-stage valid/ready pipeline around gate_unit_core with zero/all-ones flags.
// Optional accepted-transaction counter op_count when GATE_UNIT_STATUS_EN is defined.
module gate_unit_pipe
  import gate_unit_pkg::*;
#(
  parameter int WIDTH = 8
`ifdef GATE_UNIT_STATUS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             all_ones
`ifdef GATE_UNIT_STATUS_EN
  , output logic [CNT_W-1:0] op_count
`endif
);

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [OP_W-1:0]  r_s1_op;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_y;
  logic             r_zero;
  logic             r_all_ones;

  logic             w_s1_adv;
  logic             w_s2_adv;
  logic [WIDTH-1:0] w_y;

  // in_ready follows out_ready combinationally so a full pipe can advance in one cycle
  assign w_s2_adv = !r_out_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  gate_unit_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .i_op(r_s1_op),
    .i_a (r_s1_a),
    .i_b (r_s1_b),
    .o_y (w_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_op    <= OP_AND;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_a  <= a;
        r_s1_b  <= b;
        r_s1_op <= op;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_zero      <= 1'b0;
      r_all_ones  <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_y        <= w_y;
        r_zero     <= (w_y == '0);
        r_all_ones <= (w_y == '1);
      end
    end
  end

  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign zero      = r_zero;
  assign all_ones  = r_all_ones;

`ifdef GATE_UNIT_STATUS_EN
  logic [CNT_W-1:0] r_op_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_count <= '0;
    end else if (in_valid && w_s1_adv) begin
      r_op_count <= r_op_count + CNT_W'(1);
    end
  end

  assign op_count = r_op_count;
`endif

endmodule
